// File: rtl/wb_interconnect_pkg.sv
// Shared types and helpers for the round-robin Wishbone interconnect.
//   slv_state_e : per-slave ownership state (idle / owned by one master)
//   id_width()  : index width for N ports, never less than 1 bit
//   in_range()  : inclusive unsigned {base, limit} address match
package wb_interconnect_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } slv_state_e;

    localparam int unsigned MAX_PORTS = 16;
    localparam int unsigned DEC_W     = 64;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic logic in_range(input logic [DEC_W-1:0] addr,
                                      input logic [DEC_W-1:0] base,
                                      input logic [DEC_W-1:0] limit);
        return (base <= addr) && (addr <= limit);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter for one slave port.
//   clk, rstn : clock, async active-low reset
//   req       : per-master request vector
//   load      : when high and any req is set, the winner is registered
//   grant     : registered winner; doubles as last_grant (resets to N-1)
module wb_rr_arbiter
    import wb_interconnect_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          load,
    output logic [IW-1:0] grant
);

    logic [IW-1:0] pick;
    logic          found;
    logic [N-1:0]  rot;
    int unsigned   idx;

    // Search starts one past the previous winner and wraps around.
    always_comb begin
        pick  = grant;
        found = 1'b0;
        rot   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(grant) + k) % N;
            rot = req >> idx;
            if (!found && rot[0]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant <= IW'(N - 1);
        end else if (load && found) begin
            grant <= pick;
        end
    end

endmodule

// File: rtl/wb_interconnect_rr.sv
// N-master / N-slave Wishbone crossbar with per-slave round-robin arbitration.
// Each slave is either idle or locked to one master for that master's whole
// CYC; request and response paths are combinational once a grant is held.
// Unmapped addresses get a one-cycle ERR one cycle after the request.
// Optional: define WB_IC_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES
// stalled cycles with ERR to the owning master.
//   clk, rstn                                 : clock, async active-low reset
//   ADR/DAT_W/SEL/CTI/BTE/CYC/STB/WE [master] : master requests
//   DAT_R/ACK/ERR [master]                    : master responses
//   SADR/SDAT_W/SSEL/SCTI/SBTE/SCYC/SSTB/SWE  : slave requests
//   SDAT_R/SACK/SERR [slave]                  : slave responses
module wb_interconnect_rr
    import wb_interconnect_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned N_MASTERS      = 4,
    parameter int unsigned N_SLAVES       = 4,
    parameter logic [N_SLAVES*2*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR    [N_MASTERS],
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W  [N_MASTERS],
    input  logic [WB_DATA_WIDTH/8-1:0] SEL    [N_MASTERS],
    input  logic [2:0]                 CTI    [N_MASTERS],
    input  logic [1:0]                 BTE    [N_MASTERS],
    input  logic                       CYC    [N_MASTERS],
    input  logic                       STB    [N_MASTERS],
    input  logic                       WE     [N_MASTERS],
    output logic [WB_DATA_WIDTH-1:0]   DAT_R  [N_MASTERS],
    output logic                       ACK    [N_MASTERS],
    output logic                       ERR    [N_MASTERS],
    output logic [WB_ADDR_WIDTH-1:0]   SADR   [N_SLAVES],
    output logic [WB_DATA_WIDTH-1:0]   SDAT_W [N_SLAVES],
    output logic [WB_DATA_WIDTH/8-1:0] SSEL   [N_SLAVES],
    output logic [2:0]                 SCTI   [N_SLAVES],
    output logic [1:0]                 SBTE   [N_SLAVES],
    output logic                       SCYC   [N_SLAVES],
    output logic                       SSTB   [N_SLAVES],
    output logic                       SWE    [N_SLAVES],
    input  logic [WB_DATA_WIDTH-1:0]   SDAT_R [N_SLAVES],
    input  logic                       SACK   [N_SLAVES],
    input  logic                       SERR   [N_SLAVES]
);

    localparam int unsigned AW    = WB_ADDR_WIDTH;
    localparam int unsigned MID_W = id_width(N_MASTERS);
    localparam int unsigned SID_W = id_width(N_SLAVES);

    // Reject configurations outside the supported envelope at elaboration.
    if (N_MASTERS < 1 || N_MASTERS > MAX_PORTS || N_SLAVES < 1 || N_SLAVES > MAX_PORTS ||
        AW > DEC_W || TIMEOUT_CYCLES < 1 || (WB_DATA_WIDTH % 8) != 0) begin : g_bad_cfg
        $error("wb_interconnect_rr: unsupported parameter set");
    end

    logic [AW-1:0]        base_c  [N_SLAVES];
    logic [AW-1:0]        limit_c [N_SLAVES];
    logic [N_MASTERS-1:0] hit;
    logic [SID_W-1:0]     sel     [N_MASTERS];
    logic [N_MASTERS-1:0] req_vec [N_SLAVES];
    logic [N_MASTERS-1:0] err_q;
    slv_state_e           state   [N_SLAVES];
    logic [MID_W-1:0]     owner   [N_SLAVES];
    logic [N_SLAVES-1:0]  tmo_c;

    // Slave 0 sits in the most-significant {base, limit} pair.
    for (genvar s = 0; s < int'(N_SLAVES); s++) begin : g_rng
        assign base_c[s]  = ADDR_RANGES[(N_SLAVES - s) * 2 * AW - 1 -: AW];
        assign limit_c[s] = ADDR_RANGES[(N_SLAVES - s) * 2 * AW - AW - 1 -: AW];
    end

    // Address decode; scanning downward lets the lowest matching slave win.
    always_comb begin
        for (int m = 0; m < int'(N_MASTERS); m++) begin
            hit[m] = 1'b0;
            sel[m] = '0;
            for (int s = int'(N_SLAVES) - 1; s >= 0; s--) begin
                if (in_range(DEC_W'(ADR[m]), DEC_W'(base_c[s]), DEC_W'(limit_c[s]))) begin
                    hit[m] = 1'b1;
                    sel[m] = SID_W'(s);
                end
            end
        end
    end

    // Per-slave request vectors.
    always_comb begin
        for (int s = 0; s < int'(N_SLAVES); s++) begin
            req_vec[s] = '0;
            for (int m = 0; m < int'(N_MASTERS); m++) begin
                req_vec[s][m] = CYC[m] && STB[m] && hit[m] && (sel[m] == SID_W'(s));
            end
        end
    end

    for (genvar s = 0; s < int'(N_SLAVES); s++) begin : g_arb
        wb_rr_arbiter #(
            .N (N_MASTERS)
        ) u_arb (
            .clk   (clk),
            .rstn  (rstn),
            .req   (req_vec[s]),
            .load  (state[s] == ST_IDLE),
            .grant (owner[s])
        );
    end

`ifdef WB_IC_TIMEOUT_EN
    localparam int unsigned TW = id_width(TIMEOUT_CYCLES);

    logic [TW-1:0]       tmo_cnt [N_SLAVES];
    logic [N_SLAVES-1:0] stall_c;

    // A stall is a strobed cycle the slave neither acks nor errors.
    always_comb begin
        for (int s = 0; s < int'(N_SLAVES); s++) begin
            stall_c[s] = (state[s] == ST_OWNED) && CYC[owner[s]] && STB[owner[s]] &&
                         !SACK[s] && !SERR[s];
            tmo_c[s]   = stall_c[s] && (tmo_cnt[s] == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < int'(N_SLAVES); s++) tmo_cnt[s] <= '0;
        end else begin
            for (int s = 0; s < int'(N_SLAVES); s++) begin
                if (!stall_c[s] || tmo_c[s]) tmo_cnt[s] <= '0;
                else                         tmo_cnt[s] <= tmo_cnt[s] + TW'(1);
            end
        end
    end
`else
    assign tmo_c = '0;
`endif

    // Ownership FSMs and the unmapped-address error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < int'(N_SLAVES); s++) state[s] <= ST_IDLE;
            err_q <= '0;
        end else begin
            for (int s = 0; s < int'(N_SLAVES); s++) begin
                if (state[s] == ST_IDLE) begin
                    if (|req_vec[s]) state[s] <= ST_OWNED;
                end else if (!CYC[owner[s]] || tmo_c[s]) begin
                    state[s] <= ST_IDLE;
                end
            end
            for (int m = 0; m < int'(N_MASTERS); m++) begin
                err_q[m] <= CYC[m] && STB[m] && !hit[m] && !err_q[m];
            end
        end
    end

    // Slave-side mux: owner's request, or all zeros when idle.
    always_comb begin
        for (int s = 0; s < int'(N_SLAVES); s++) begin
            SADR[s]   = '0;
            SDAT_W[s] = '0;
            SSEL[s]   = '0;
            SCTI[s]   = '0;
            SBTE[s]   = '0;
            SCYC[s]   = 1'b0;
            SSTB[s]   = 1'b0;
            SWE[s]    = 1'b0;
            if (state[s] == ST_OWNED) begin
                SADR[s]   = ADR[owner[s]];
                SDAT_W[s] = DAT_W[owner[s]];
                SSEL[s]   = SEL[owner[s]];
                SCTI[s]   = CTI[owner[s]];
                SBTE[s]   = BTE[owner[s]];
                SCYC[s]   = CYC[owner[s]] && !tmo_c[s];
                SSTB[s]   = STB[owner[s]] && !tmo_c[s];
                SWE[s]    = WE[owner[s]];
            end
        end
    end

    // Master-side return: only the owning master sees a slave's response.
    always_comb begin
        for (int m = 0; m < int'(N_MASTERS); m++) begin
            ACK[m]   = 1'b0;
            ERR[m]   = err_q[m];
            DAT_R[m] = '0;
            for (int s = 0; s < int'(N_SLAVES); s++) begin
                if ((state[s] == ST_OWNED) && (owner[s] == MID_W'(m))) begin
                    ACK[m]   = ACK[m] | SACK[s];
                    ERR[m]   = ERR[m] | SERR[s] | tmo_c[s];
                    DAT_R[m] = DAT_R[m] | SDAT_R[s];
                end
            end
        end
    end

endmodule

// File: doc/wb_interconnect_rr.md
WB_INTERCONNECT_RR -- requirements
Module: wb_interconnect_rr

Interface
REQ-001 The block SHALL have parameter WB_ADDR_WIDTH, default 32, address width.
REQ-002 The block SHALL have parameter WB_DATA_WIDTH, default 32, data width; SEL width is WB_DATA_WIDTH/8.
REQ-003 The block SHALL have parameter N_MASTERS, default 4, number of master ports, 1..16.
REQ-004 The block SHALL have parameter N_SLAVES, default 4, number of slave ports, 1..16.
REQ-005 The block SHALL have parameter ADDR_RANGES, default all-zero, packed {base,limit} pairs with slave 0 in the most-significant pair.
REQ-006 The block SHALL have parameter TIMEOUT_CYCLES, default 256, slave-response timeout.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-008 The block SHALL have port rstn, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have ports ADR, DAT_W, SEL, CTI, BTE, CYC, STB, WE, inputs, unpacked [N_MASTERS], carrying master requests.
REQ-010 The block SHALL have ports DAT_R, ACK, ERR, outputs, unpacked [N_MASTERS], carrying master responses.
REQ-011 The block SHALL have ports SADR, SDAT_W, SSEL, SCTI, SBTE, SCYC, SSTB, SWE, outputs, unpacked [N_SLAVES], carrying slave requests.
REQ-012 The block SHALL have ports SDAT_R, SACK, SERR, inputs, unpacked [N_SLAVES], carrying slave responses.

Function
REQ-013 Decode SHALL select slave i when base_i <= ADR <= limit_i, unsigned; on overlapping ranges the lowest i SHALL win.
REQ-014 Each slave SHALL own a 2-state FSM: IDLE and OWNED(g), where g is the granted master index.
REQ-015 In IDLE, requesters SHALL be masters with CYC&STB decoding to this slave; the grant SHALL be round-robin starting at last_grant+1 mod N_MASTERS, and SHALL register next cycle (1-cycle arbitration latency).
REQ-016 In OWNED(g), SCYC/SSTB/SWE/SADR/SDAT_W/SSEL/SCTI/SBTE SHALL pass combinationally from master g, and SACK/SERR/SDAT_R SHALL return combinationally to master g only.
REQ-017 OWNED(g) SHALL return to IDLE on the cycle master g deasserts CYC; grant SHALL be held for the whole CYC (locked bursts, CTI/BTE passed through unmodified).
REQ-018 A master SHALL request at most one slave at a time; non-granted masters SHALL see ACK=0, ERR=0, DAT_R=0.
REQ-019 A master with CYC&STB whose address matches no range SHALL receive ERR for exactly one cycle, one cycle after the request; no slave SHALL see the cycle.
REQ-020 If master g drops CYC and another master requests in the same cycle, the slave SHALL pass through IDLE for one cycle before the new grant.
REQ-021 When slaves are IDLE, SCYC and SSTB SHALL be 0; other slave outputs SHALL be 0.
REQ-022 last_grant SHALL update only on a new grant; with a single requester, that requester SHALL be granted regardless of last_grant.

Reset
REQ-023 On rstn low, all slave FSMs SHALL go to IDLE, last_grant SHALL be N_MASTERS-1, timeout counters SHALL be 0, and ACK, ERR, SCYC, SSTB SHALL be 0 immediately; a transfer in flight SHALL be abandoned without response.

Configuration
REQ-024 With WB_IC_TIMEOUT_EN defined, each OWNED slave SHALL count cycles with SSTB high and no SACK/SERR; at TIMEOUT_CYCLES it SHALL return ERR to the master for one cycle, deassert SSTB/SCYC, and go to IDLE. Without WB_IC_TIMEOUT_EN, no counter SHALL exist and a hung slave SHALL hold the grant indefinitely.

Structure
REQ-025 Package wb_interconnect_pkg SHALL hold the FSM state enum, range-decode function, and id-width constants ($clog2-based, minimum 1).
REQ-026 Sub-module wb_rr_arbiter (N-request round-robin, registered grant and last_grant) SHALL be instantiated once per slave.

Verification
REQ-027 Single master 0 writes 0xDEADBEEF to slave-1 range -> SCYC[1]/SSTB[1] rise 1 cycle after request, SACK[1] returns as ACK[0].
REQ-028 Masters 0 and 2 request slave 0 simultaneously after reset -> master 0 granted first, master 2 next; repeat -> master 2 then 0 is not repeated, order follows rotation.
REQ-029 Master 1 accesses address outside all ranges -> ERR[1] high exactly one cycle, all SCYC stay 0.
REQ-030 4-beat incrementing burst (CTI=010, final 111) by master 3 while master 0 requests the same slave -> master 3 holds grant until CYC drops, then master 0 granted after one IDLE cycle.
REQ-031 With WB_IC_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ACKs -> ERR to master on cycle 8 of the stall, slave returns to IDLE.
REQ-032 rstn asserted mid-burst -> ACK/ERR/SCYC/SSTB go 0 asynchronously; after release, the first request is granted normally.
